apb_ucpd_reg: RTL and testbench



---
 rtl/apb_ucpd_reg.sv | 186 ++++++++++++++++++
 tb/tb_apb_ucpd_reg.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_ucpd_reg.sv
// apb_ucpd_reg -- UCPD register file, event flags, TX byte buffer and RX path.
//
// Sits behind the APB BIU and consumes its decoded strobes. Read data on
// iprdata is combinational; the BIU registers it onto prdata.
//
// Ports:
//   pclk, preset                 clock, synchronous active-high reset
//   wr_en, rd_en, byte_en,
//   reg_addr, ipwdata, iprdata   decoded register access from the BIU
//   ucpd_en, tx_send, tx_paysz   control toward the PD core
//   tx_data, tx_valid, tx_ready  TX byte buffer handshake
//   tx_msg_sent/abt/disc         TX event pulses
//   rx_data, rx_valid            RX byte push (no backpressure)
//   rx_ord_det, rx_msg_end       RX event pulses
//   ucpd_irq                     registered |(SR & IMR)
//
// Build option: define UCPD_RX_FIFO_EN for an RX_FIFO_DEPTH-entry RX FIFO;
// otherwise the RX path is a single holding register (depth-1 FIFO).

module apb_ucpd_reg #(
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [3:0]  byte_en,
    input  logic [5:0]  reg_addr,
    input  logic [31:0] ipwdata,
    output logic [31:0] iprdata,
    output logic        ucpd_en,
    output logic        tx_send,
    output logic [9:0]  tx_paysz,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic        tx_msg_sent,
    input  logic        tx_msg_abt,
    input  logic        tx_msg_disc,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_ord_det,
    input  logic        rx_msg_end,
    output logic        ucpd_irq
);

    logic       cfg_q, cfg_d;
    logic [7:0] imr_q;
    logic [9:0] paysz_q;
    logic [7:0] sticky_q, sticky_d;
    logic [7:0] txd_q;
    logic       txv_q, txsend_q, irq_q;
    logic [7:0] sr, clr, hw_set;
    logic       flush, wr_cr, wr_icr, wr_txdr, tx_hs, tx_load;
    logic       push_req, push, pop, ovr_set, rx_empty, rx_full;
    logic [7:0] rx_head;
    logic       unused_bits;

    assign unused_bits = ^{ipwdata[31:16], byte_en[3:2]};

    assign cfg_d   = (wr_en && reg_addr == 6'd0 && byte_en[0]) ? ipwdata[0] : cfg_q;
    // Falling edge of UCPDEN flushes data paths and sticky flags on the same edge.
    assign flush   = cfg_q & ~cfg_d;
    assign wr_cr   = wr_en && reg_addr == 6'd1 && byte_en[0] && ipwdata[0] && cfg_q;
    assign wr_icr  = wr_en && reg_addr == 6'd4 && byte_en[0];
    assign wr_txdr = wr_en && reg_addr == 6'd6 && byte_en[0];

    assign tx_hs   = txv_q & tx_ready;
    // A write is accepted if the buffer is empty or draining this cycle.
    assign tx_load = wr_txdr & (~txv_q | tx_hs);

    assign pop      = rd_en && reg_addr == 6'd7 && !rx_empty;
    assign push_req = rx_valid & cfg_q;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push     = push_req & (~rx_full | pop);
    assign ovr_set  = push_req & rx_full & ~pop;

    // ICR only touches sticky bits; hardware set takes priority over clear.
    assign clr    = wr_icr ? (ipwdata[7:0] & 8'hEE) : 8'h00;
    assign hw_set = {ovr_set, rx_msg_end & cfg_q, rx_ord_det & cfg_q, 1'b0,
                     tx_msg_abt & cfg_q, tx_msg_sent & cfg_q, tx_msg_disc & cfg_q, 1'b0};
    assign sticky_d = flush ? 8'h00 : (((sticky_q & ~clr) | hw_set) & 8'hEE);

    assign sr = sticky_q | {3'b000, ~rx_empty, 3'b000, cfg_q & ~txv_q};

`ifdef UCPD_RX_FIFO_EN
    localparam int AW = $clog2(RX_FIFO_DEPTH);
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic [7:0]    mem_q [RX_FIFO_DEPTH];

    assign rx_empty = (cnt_q == '0);
    assign rx_full  = (cnt_q == (AW+1)'(RX_FIFO_DEPTH));
    assign rx_head  = mem_q[rptr_q];

    always_ff @(posedge pclk) begin
        if (preset || flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
        end
    end

    // Storage needs no reset: it is only read while the FIFO is non-empty.
    always_ff @(posedge pclk) begin
        if (push && !flush) mem_q[wptr_q] <= rx_data;
    end
`else
    logic       hold_full_q;
    logic [7:0] hold_q;
    logic       depth_unused;

    assign depth_unused = (RX_FIFO_DEPTH != 0);
    assign rx_empty = ~hold_full_q;
    assign rx_full  = hold_full_q;
    assign rx_head  = hold_q;

    always_ff @(posedge pclk) begin
        if (preset || flush) begin
            hold_full_q <= 1'b0;
            hold_q      <= 8'h00;
        end else if (push) begin
            hold_full_q <= 1'b1;
            hold_q      <= rx_data;
        end else if (pop) begin
            hold_full_q <= 1'b0;
        end
    end
`endif

    always_ff @(posedge pclk) begin
        if (preset) begin
            cfg_q    <= 1'b0;
            imr_q    <= 8'h00;
            paysz_q  <= 10'h000;
            sticky_q <= 8'h00;
            txd_q    <= 8'h00;
            txv_q    <= 1'b0;
            txsend_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            cfg_q    <= cfg_d;
            sticky_q <= sticky_d;
            txsend_q <= wr_cr;
            irq_q    <= |(sr & imr_q);
            if (wr_en && reg_addr == 6'd2 && byte_en[0]) imr_q <= ipwdata[7:0];
            if (wr_en && reg_addr == 6'd5) begin
                if (byte_en[0]) paysz_q[7:0] <= ipwdata[7:0];
                if (byte_en[1]) paysz_q[9:8] <= ipwdata[9:8];
            end
            if (flush) begin
                txv_q <= 1'b0;
            end else if (tx_load) begin
                txv_q <= 1'b1;
                txd_q <= ipwdata[7:0];
            end else if (tx_hs) begin
                txv_q <= 1'b0;
            end
        end
    end

    always_comb begin
        iprdata = 32'h0;
        case (reg_addr)
            6'd0: iprdata = {31'h0, cfg_q};
            6'd2: iprdata = {24'h0, imr_q};
            6'd3: iprdata = {24'h0, sr};
            6'd5: iprdata = {22'h0, paysz_q};
            6'd7: iprdata = rx_empty ? 32'h0 : {24'h0, rx_head};
            default: iprdata = 32'h0;
        endcase
    end

    assign ucpd_en  = cfg_q;
    assign tx_send  = txsend_q;
    assign tx_paysz = paysz_q;
    assign tx_data  = txd_q;
    assign tx_valid = txv_q;
    assign ucpd_irq = irq_q;

endmodule

// File: tb/tb_apb_ucpd_reg.sv
// Directed bench for apb_ucpd_reg. Follows whatever UCPD_RX_FIFO_EN setting
// the RTL is built with (4-deep FIFO or single holding register).
module tb_apb_ucpd_reg;

`ifdef UCPD_RX_FIFO_EN
    localparam int D = 4;
`else
    localparam int D = 1;
`endif

    logic        pclk, preset, wr_en, rd_en;
    logic [3:0]  byte_en;
    logic [5:0]  reg_addr;
    logic [31:0] ipwdata, iprdata;
    logic        ucpd_en, tx_send, tx_valid, tx_ready;
    logic [9:0]  tx_paysz;
    logic [7:0]  tx_data, rx_data;
    logic        tx_msg_sent, tx_msg_abt, tx_msg_disc;
    logic        rx_valid, rx_ord_det, rx_msg_end, ucpd_irq;

    int errors = 0;
    int checks = 0;
    logic [31:0] rd;

    apb_ucpd_reg #(.RX_FIFO_DEPTH(4)) dut (
        .pclk(pclk), .preset(preset), .wr_en(wr_en), .rd_en(rd_en),
        .byte_en(byte_en), .reg_addr(reg_addr), .ipwdata(ipwdata), .iprdata(iprdata),
        .ucpd_en(ucpd_en), .tx_send(tx_send), .tx_paysz(tx_paysz), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_msg_sent(tx_msg_sent),
        .tx_msg_abt(tx_msg_abt), .tx_msg_disc(tx_msg_disc), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ord_det(rx_ord_det), .rx_msg_end(rx_msg_end),
        .ucpd_irq(ucpd_irq)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Inputs change on the falling edge; the DUT commits on the next rising edge.
    task automatic apb_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge pclk);
        wr_en = 1'b1; reg_addr = a; ipwdata = d; byte_en = be;
        @(negedge pclk);
        wr_en = 1'b0; byte_en = 4'h0;
    endtask

    task automatic apb_read(input logic [5:0] a, output logic [31:0] d);
        @(negedge pclk);
        reg_addr = a; rd_en = 1'b1;
        #1 d = iprdata;
        @(negedge pclk);
        rd_en = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] b);
        @(negedge pclk);
        rx_data = b; rx_valid = 1'b1;
        @(negedge pclk);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] a;
        checks++;
        if ({ucpd_en, tx_send, tx_paysz, tx_data, tx_valid, ucpd_irq} !== 22'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", {ucpd_en, tx_send, tx_paysz, tx_data, tx_valid, ucpd_irq});
        end
        for (int i = 0; i < 9; i++) begin
            a = (i == 8) ? 6'h3F : 6'(i);
            apb_read(a, rd);
            checks++;
            if (rd !== 32'h0) begin
                errors++;
                $display("FAIL reset_read addr=%0d got=%h exp=0", a, rd);
            end
        end
    endtask

    task automatic test_irq();
        // Write with lane 0 disabled must not enable the block.
        apb_write(6'd0, 32'h1, 4'b1110);
        checks++;
        if (ucpd_en !== 1'b0) begin errors++; $display("FAIL cfg_lane got=%b exp=0", ucpd_en); end
        apb_write(6'd0, 32'h1, 4'hF);
        apb_write(6'd2, 32'h4, 4'hF);
        apb_read(6'd3, rd);
        checks++;
        if (rd !== 32'h01) begin errors++; $display("FAIL sr_txis got=%h exp=01", rd); end
        @(negedge pclk); tx_msg_sent = 1'b1;
        @(negedge pclk); tx_msg_sent = 1'b0;
        checks++;
        if (ucpd_irq !== 1'b0) begin errors++; $display("FAIL irq_early got=%b exp=0", ucpd_irq); end
        @(negedge pclk);
        checks++;
        if (ucpd_irq !== 1'b1) begin errors++; $display("FAIL irq_set got=%b exp=1", ucpd_irq); end
        apb_read(6'd3, rd);
        checks++;
        if (rd !== 32'h05) begin errors++; $display("FAIL sr_sent got=%h exp=05", rd); end
        apb_write(6'd4, 32'h4, 4'h1);
        apb_read(6'd3, rd);
        checks++;
        if (rd !== 32'h01) begin errors++; $display("FAIL sr_icr got=%h exp=01", rd); end
        @(negedge pclk);
        checks++;
        if (ucpd_irq !== 1'b0) begin errors++; $display("FAIL irq_clr got=%b exp=0", ucpd_irq); end
    endtask

    task automatic test_paysz_lanes();
        apb_write(6'd5, 32'h3FF, 4'b0001);
        checks++;
        if (tx_paysz !== 10'h0FF) begin errors++; $display("FAIL paysz_lo got=%h exp=0ff", tx_paysz); end
        apb_write(6'd5, 32'h2AB, 4'b0010);
        apb_read(6'd5, rd);
        checks++;
        if (rd !== 32'h2FF) begin errors++; $display("FAIL paysz_hi got=%h exp=2ff", rd); end
    endtask

    task automatic test_tx();
        apb_write(6'd6, 32'hA5, 4'h1);
        checks++;
        if ({tx_valid, tx_data} !== 9'h1A5) begin errors++; $display("FAIL tx_load got=%h exp=1a5", {tx_valid, tx_data}); end
        apb_read(6'd3, rd);
        checks++;
        if (rd !== 32'h00) begin errors++; $display("FAIL tx_txis got=%h exp=00", rd); end
        apb_write(6'd6, 32'h3C, 4'h1);
        checks++;
        if ({tx_valid, tx_data} !== 9'h1A5) begin errors++; $display("FAIL tx_full_drop got=%h exp=1a5", {tx_valid, tx_data}); end
        @(negedge pclk); tx_ready = 1'b1;
        @(negedge pclk); tx_ready = 1'b0;
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_handshake got=%b exp=0", tx_valid); end
        // Handshake and write on the same edge keep the buffer full with the new byte.
        apb_write(6'd6, 32'h55, 4'h1);
        @(negedge pclk);
        tx_ready = 1'b1; wr_en = 1'b1; reg_addr = 6'd6; byte_en = 4'h1; ipwdata = 32'h77;
        @(negedge pclk);
        tx_ready = 1'b0; wr_en = 1'b0; byte_en = 4'h0;
        checks++;
        if ({tx_valid, tx_data} !== 9'h177) begin errors++; $display("FAIL tx_hs_write got=%h exp=177", {tx_valid, tx_data}); end
        @(negedge pclk); tx_ready = 1'b1;
        @(negedge pclk); tx_ready = 1'b0;
        apb_write(6'd1, 32'h1, 4'h1);
        checks++;
        if (tx_send !== 1'b1) begin errors++; $display("FAIL tx_send_hi got=%b exp=1", tx_send); end
        @(negedge pclk);
        checks++;
        if (tx_send !== 1'b0) begin errors++; $display("FAIL tx_send_lo got=%b exp=0", tx_send); end
        apb_read(6'd1, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL cr_read got=%h exp=0", rd); end
    endtask

    task automatic test_rx();
        for (int i = 0; i <= D; i++) rx_push(8'(17 * (i + 1)));
        apb_read(6'd3, rd);
        checks++;
        if (rd !== 32'h91) begin errors++; $display("FAIL rx_ovr_sr got=%h exp=91", rd); end
        for (int i = 0; i < D; i++) begin
            apb_read(6'd7, rd);
            checks++;
            if (rd !== 32'(17 * (i + 1))) begin errors++; $display("FAIL rx_pop%0d got=%h exp=%h", i, rd, 32'(17 * (i + 1))); end
        end
        apb_read(6'd7, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL rx_empty_read got=%h exp=0", rd); end
        apb_read(6'd3, rd);
        checks++;
        if (rd !== 32'h81) begin errors++; $display("FAIL rx_rxne_clr got=%h exp=81", rd); end
        apb_write(6'd4, 32'h80, 4'h1);
        // Full FIFO with push and pop on the same edge: no overflow, order kept.
        for (int i = 0; i < D; i++) rx_push(8'(8'hA0 + i));
        @(negedge pclk);
        rx_data = 8'hEE; rx_valid = 1'b1; reg_addr = 6'd7; rd_en = 1'b1;
        #1 rd = iprdata;
        @(negedge pclk);
        rx_valid = 1'b0; rd_en = 1'b0;
        checks++;
        if (rd !== 32'hA0) begin errors++; $display("FAIL rx_pushpop_head got=%h exp=a0", rd); end
        apb_read(6'd3, rd);
        checks++;
        if (rd !== 32'h11) begin errors++; $display("FAIL rx_pushpop_sr got=%h exp=11", rd); end
        for (int i = 1; i <= D; i++) begin
            apb_read(6'd7, rd);
            checks++;
            if (rd !== ((i == D) ? 32'hEE : 32'(8'hA0 + i))) begin
                errors++; $display("FAIL rx_drain%0d got=%h", i, rd);
            end
        end
    endtask

    task automatic test_set_wins();
        @(negedge pclk);
        rx_msg_end = 1'b1; wr_en = 1'b1; reg_addr = 6'd4; byte_en = 4'h1; ipwdata = 32'h40;
        @(negedge pclk);
        rx_msg_end = 1'b0; wr_en = 1'b0; byte_en = 4'h0;
        apb_read(6'd3, rd);
        checks++;
        if (rd !== 32'h41) begin errors++; $display("FAIL set_wins got=%h exp=41", rd); end
        apb_write(6'd4, 32'h40, 4'h1);
        apb_read(6'd3, rd);
        checks++;
        if (rd !== 32'h01) begin errors++; $display("FAIL icr_rxend got=%h exp=01", rd); end
    endtask

    task automatic test_disable();
        apb_write(6'd2, 32'h08, 4'h1);
        for (int i = 0; i < D; i++) rx_push(8'(8'h60 + i));
        @(negedge pclk); tx_msg_abt = 1'b1;
        @(negedge pclk); tx_msg_abt = 1'b0;
        apb_write(6'd6, 32'h5A, 4'h1);
        apb_read(6'd3, rd);
        checks++;
        if (rd !== 32'h18) begin errors++; $display("FAIL dis_pre_sr got=%h exp=18", rd); end
        checks++;
        if (ucpd_irq !== 1'b1) begin errors++; $display("FAIL dis_pre_irq got=%b exp=1", ucpd_irq); end
        apb_write(6'd0, 32'h0, 4'h1);
        checks++;
        if ({ucpd_en, tx_valid} !== 2'b00) begin errors++; $display("FAIL dis_flags got=%b exp=00", {ucpd_en, tx_valid}); end
        apb_read(6'd3, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL dis_sr got=%h exp=0", rd); end
        apb_read(6'd2, rd);
        checks++;
        if (rd !== 32'h08) begin errors++; $display("FAIL dis_imr got=%h exp=08", rd); end
        checks++;
        if (tx_paysz !== 10'h2FF) begin errors++; $display("FAIL dis_paysz got=%h exp=2ff", tx_paysz); end
        apb_read(6'd7, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL dis_rxdr got=%h exp=0", rd); end
        checks++;
        if (ucpd_irq !== 1'b0) begin errors++; $display("FAIL dis_irq got=%b exp=0", ucpd_irq); end
        apb_write(6'd1, 32'h1, 4'h1);
        checks++;
        if (tx_send !== 1'b0) begin errors++; $display("FAIL dis_txsend got=%b exp=0", tx_send); end
        rx_push(8'h99);
        @(negedge pclk); tx_msg_sent = 1'b1;
        @(negedge pclk); tx_msg_sent = 1'b0;
        apb_read(6'd3, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL dis_capture got=%h exp=0", rd); end
    endtask

    initial begin
        preset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; byte_en = 4'h0; reg_addr = 6'h0;
        ipwdata = 32'h0; tx_ready = 1'b0; tx_msg_sent = 1'b0; tx_msg_abt = 1'b0;
        tx_msg_disc = 1'b0; rx_data = 8'h0; rx_valid = 1'b0; rx_ord_det = 1'b0; rx_msg_end = 1'b0;
        repeat (3) @(negedge pclk);
        preset = 1'b0;
        test_reset();
        test_irq();
        test_paysz_lanes();
        test_tx();
        test_rx();
        test_set_wins();
        test_disable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
